// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: NOP encoding, MIPS field helpers and
// the next-PC source selector used by the PC mux.
// Optional feature macro consumed elsewhere: FETCH_BRANCH_DELAY_SLOT_EN.
package fetch_stage_pkg;

    // sll $0,$0,0
    localparam logic [31:0] NOP_ENCODING = 32'h0000_0000;

    // Next-PC source; Hold outranks the redirects, redirects outrank sequential.
    typedef enum logic [1:0] {
        PcSeq,
        PcHold,
        PcJump,
        PcBranch
    } pc_sel_e;

    // Immediate [15:0] sign-extended and scaled to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // Jump index [25:0] placed into the current 256 MB region.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus_4,
                                                input logic [25:0] index);
        return {pc_plus_4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its surroundings (instruction memory, hazard
// unit, decode stage).
//   imem_addr/imem_data : fetch address and combinational instruction read
//   stall/jump/branch_taken : hazard hold and decode-stage redirect requests
//   pc_f, instruction, pc_plus_4_d, valid_d : fetch PC and IF/ID contents
// master: the fetch stage.  slave: memory/decode/hazard side.
interface fetch_stage_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        jump;
    logic        branch_taken;
    logic [31:0] pc_f;
    logic [31:0] instruction;
    logic [31:0] pc_plus_4_d;
    logic        valid_d;

    modport master (
        output imem_addr, pc_f, instruction, pc_plus_4_d, valid_d,
        input  imem_data, stall, jump, branch_taken
    );

    modport slave (
        input  imem_addr, pc_f, instruction, pc_plus_4_d, valid_d,
        output imem_data, stall, jump, branch_taken
    );

endinterface

// File: rtl/fetch_stage_branch_target_unit.sv
// branch_target_unit: combinational jump/branch target computation from the
// IF/ID register contents. All arithmetic wraps mod 2^32.
//   pc_plus_4_d in 32 : PC+4 of the latched instruction
//   instruction in 32 : latched instruction word
//   jtarget     out 32 : J-type target
//   btarget     out 32 : BEQ/BNE target
module branch_target_unit
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc_plus_4_d,
    input  logic [31:0] instruction,
    output logic [31:0] jtarget,
    output logic [31:0] btarget
);

    assign jtarget = jump_target(pc_plus_4_d, instruction[25:0]);
    assign btarget = pc_plus_4_d + branch_offset(instruction[15:0]);

    // Opcode field is decoded upstream; not needed for target arithmetic.
    logic unused_opcode;
    assign unused_opcode = ^instruction[31:26];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage plus IF/ID pipeline register. Holds the PC, drives
// the instruction memory address, latches the fetched word and redirects on
// decode-stage jump / taken-branch requests.
//   clock, reset : single clock, synchronous active-high reset
//   bus (master) : imem_addr/imem_data, stall, jump, branch_taken,
//                  pc_f, instruction, pc_plus_4_d, valid_d
// Parameters: RESET_PC (PC after reset), NOP_WORD (bubble word in IF/ID).
// Macro FETCH_BRANCH_DELAY_SLOT_EN: when defined, the word fetched alongside a
// redirect enters IF/ID as a valid delay-slot instruction instead of being
// squashed.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP_WORD = NOP_ENCODING
) (
    input logic           clock,
    input logic           reset,
    fetch_stage_if.master bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pp4_q, pp4_d;
    logic        valid_q, valid_nxt;
    logic [31:0] pc_plus_4;
    logic [31:0] jtarget, btarget;
    logic        squash;
    pc_sel_e     pc_sel;

    assign pc_plus_4 = pc_q + 32'd4;

    branch_target_unit u_branch_target_unit (
        .pc_plus_4_d (pp4_q),
        .instruction (instr_q),
        .jtarget     (jtarget),
        .btarget     (btarget)
    );

    // A bubble in IF/ID never redirects; jump beats branch_taken.
    always_comb begin
        pc_sel = PcSeq;
        if (bus.stall) begin
            pc_sel = PcHold;
        end else if (valid_q && bus.jump) begin
            pc_sel = PcJump;
        end else if (valid_q && bus.branch_taken) begin
            pc_sel = PcBranch;
        end
    end

    always_comb begin
        pc_d = pc_plus_4;
        unique case (pc_sel)
            PcHold:   pc_d = pc_q;
            PcJump:   pc_d = jtarget;
            PcBranch: pc_d = btarget;
            default:  pc_d = pc_plus_4;
        endcase
    end

`ifdef FETCH_BRANCH_DELAY_SLOT_EN
    // Delay-slot word is architecturally executed; nothing is squashed.
    assign squash = 1'b0;
`else
    // The word fetched in the redirect cycle is on the wrong path.
    assign squash = (pc_sel == PcJump) || (pc_sel == PcBranch);
`endif

    always_comb begin
        instr_d   = bus.imem_data;
        pp4_d     = pc_plus_4;
        valid_nxt = 1'b1;
        if (bus.stall) begin
            instr_d   = instr_q;
            pp4_d     = pp4_q;
            valid_nxt = valid_q;
        end else if (squash) begin
            instr_d   = NOP_WORD;
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pp4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pp4_q   <= pp4_d;
            valid_q <= valid_nxt;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.pc_f        = pc_q;
    assign bus.instruction = instr_q;
    assign bus.pc_plus_4_d = pp4_q;
    assign bus.valid_d     = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural fetch model checked every
// cycle, plus hand-computed literal pins along a directed script.
module tb_fetch_stage;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    fetch_stage_if bus ();

    fetch_stage u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction memory: a few programmed words, others tagged with the address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h1000_FFFE;  // beq, offset -2
            32'h0040_0000: return 32'h0800_0000;  // j 0x00000000
            32'h0040_0004: return 32'h0810_0010;  // j 0x00400040
            32'h0040_000C: return 32'h1000_FFFF;  // beq, offset -1
            default:       return a ^ 32'h5A00_0000;
        endcase
    endfunction

    always_comb bus.imem_data = mem(bus.imem_addr);

    int n_tests = 0;
    int n_fail  = 0;
    int decoder_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state.
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid;
    bit          m_pp4_known = 1'b0;
    bit          m_ready = 1'b0;

    always @(posedge clock) begin : model
        logic [31:0] tgt;
        logic        redir;
        if (reset) begin
            m_pc        <= 32'h0040_0000;
            m_instr     <= 32'h0000_0000;
            m_pp4       <= 32'h0000_0000;
            m_valid     <= 1'b0;
            m_pp4_known <= 1'b1;
            m_ready     <= 1'b1;
        end else if (m_ready && !bus.stall) begin
            redir = m_valid && (bus.jump || bus.branch_taken);
            if (bus.jump)
                tgt = (m_pp4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
            else
                tgt = m_pp4 + (32'($signed(m_instr[15:0])) << 2);
            if (m_valid && bus.jump && bus.branch_taken) begin
                decoder_errors++;
                $display("[TB] note: decoder error, jump and branch_taken both set at %0t",
                         $time);
            end
            m_pc <= redir ? tgt : m_pc + 32'd4;
`ifdef FETCH_BRANCH_DELAY_SLOT_EN
            m_instr     <= mem(m_pc);
            m_pp4       <= m_pc + 32'd4;
            m_valid     <= 1'b1;
            m_pp4_known <= 1'b1;
`else
            if (redir) begin
                m_instr     <= 32'h0000_0000;
                m_valid     <= 1'b0;
                m_pp4_known <= 1'b0;
            end else begin
                m_instr     <= mem(m_pc);
                m_pp4       <= m_pc + 32'd4;
                m_valid     <= 1'b1;
                m_pp4_known <= 1'b1;
            end
`endif
        end
    end

    always @(negedge clock) begin
        if (m_ready) begin
            check("pc_f", bus.pc_f, m_pc);
            check("imem_addr", bus.imem_addr, m_pc);
            check("instruction", bus.instruction, m_instr);
            check("valid_d", {31'b0, bus.valid_d}, {31'b0, m_valid});
            if (m_pp4_known) check("pc_plus_4_d", bus.pc_plus_4_d, m_pp4);
        end
    end

    task automatic step(input logic s, input logic j, input logic b, input logic r);
        bus.stall        = s;
        bus.jump         = j;
        bus.branch_taken = b;
        reset            = r;
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.stall        = 1'b0;
        bus.jump         = 1'b0;
        bus.branch_taken = 1'b0;
        reset            = 1'b1;

        // Reset state.
        step(0, 0, 0, 1);
        check("rst_pc", bus.pc_f, 32'h0040_0000);
        check("rst_instr", bus.instruction, 32'h0000_0000);
        check("rst_pp4", bus.pc_plus_4_d, 32'h0000_0000);
        check("rst_valid", {31'b0, bus.valid_d}, 32'd0);

        // Free run; jump on a bubble must be ignored.
        step(0, 1, 0, 0);
        check("bubble_no_redirect_pc", bus.pc_f, 32'h0040_0004);
        check("lag_instr", bus.instruction, 32'h0800_0000);
        check("valid_up", {31'b0, bus.valid_d}, 32'd1);
        step(0, 0, 0, 0);
        check("seq_pc", bus.pc_f, 32'h0040_0008);
        check("j_in_ifid", bus.instruction, 32'h0810_0010);
        check("j_pp4", bus.pc_plus_4_d, 32'h0040_0008);

        // Jump.
        step(0, 1, 0, 0);
        check("jump_pc", bus.pc_f, 32'h0040_0040);
`ifdef FETCH_BRANCH_DELAY_SLOT_EN
        check("slot_valid", {31'b0, bus.valid_d}, 32'd1);
        check("slot_instr", bus.instruction, 32'h5A40_0008);
`else
        check("squash_valid", {31'b0, bus.valid_d}, 32'd0);
        check("squash_instr", bus.instruction, 32'h0000_0000);
`endif

        // Taken branch with negative offset.
        step(0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0);
        check("beq_in_ifid", bus.instruction, 32'h1000_FFFF);
        check("beq_pp4", bus.pc_plus_4_d, 32'h0040_0010);
        step(0, 0, 1, 0);
        check("branch_pc", bus.pc_f, 32'h0040_000C);

        // Stall holds everything and blocks the redirect; jump taken once after.
        step(0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0);
            check("stall_pc", bus.pc_f, 32'h0040_0008);
            check("stall_instr", bus.instruction, 32'h0810_0010);
            check("stall_valid", {31'b0, bus.valid_d}, 32'd1);
        end
        step(0, 1, 0, 0);
        check("post_stall_jump", bus.pc_f, 32'h0040_0040);
        step(0, 0, 0, 0);
        check("jump_once", bus.pc_f, 32'h0040_0044);

        // Jump and branch together: jump wins.
        step(0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        check("jump_beats_branch", bus.pc_f, 32'h0040_0040);

        // PC wrap: jump to 0, branch back to FFFFFFFC, then sequential to 0.
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        check("jump_zero", bus.pc_f, 32'h0000_0000);
        step(0, 0, 0, 0);
        check("beq_low_pp4", bus.pc_plus_4_d, 32'h0000_0004);
        step(0, 0, 1, 0);
        check("branch_wrap_pc", bus.pc_f, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        check("wrap_pc", bus.pc_f, 32'h0000_0000);
        check("wrap_pp4", bus.pc_plus_4_d, 32'h0000_0000);

        // Reset together with a redirect request.
        step(0, 0, 0, 0);
        step(0, 0, 1, 1);
        check("rst_redir_pc", bus.pc_f, 32'h0040_0000);
        check("rst_redir_instr", bus.instruction, 32'h0000_0000);
        check("rst_redir_valid", {31'b0, bus.valid_d}, 32'd0);
        repeat (2) step(0, 0, 0, 0);
        check("after_rst_pc", bus.pc_f, 32'h0040_0008);

        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
